rgb_led_pwm: RTL



---
 rtl/rgb_led_pwm.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: memory-mapped three-channel PWM driver for the board RGB LED.
// Each channel has an 8-bit brightness and an optional linear fade toward a
// target. Duty changes are latched only at a PWM period boundary, so the LED
// pins never show a truncated or stretched pulse.
module rgb_led_pwm #(
  parameter int FREQUENCY = 100_000_000,
  parameter int PWM_HZ    = 1000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic [2:0]  o_led
);

  // Clocks per PWM tick, never below one.
  localparam int PRESCALE_RAW = FREQUENCY / (PWM_HZ * 256);
  localparam int PRESCALE     = (PRESCALE_RAW < 1) ? 1 : PRESCALE_RAW;
  localparam int PRESC_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  // Register map (word index).
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_TARGET  = 3'd1;
  localparam logic [2:0] ADDR_FADE    = 3'd2;
  localparam logic [2:0] ADDR_CURRENT = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  logic               enable_reg;
  logic               invert_reg;
  logic [15:0]        fade_reg;
  logic [15:0]        step_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [7:0]         period_reg;
  logic               ready_reg;
  logic [31:0]        rdata_reg;

  logic [23:0]        target_bus;
  logic [23:0]        current_bus;
  logic               wr_ctrl;
  logic               wr_target;
  logic               wr_fade;
  logic               step_wrap;
  logic               presc_wrap;
  logic               period_wrap;
  logic               busy;
  logic [31:0]        read_data;
  logic               unused_wdata;

  // Write strobes; read-only and unmapped indexes simply have no strobe.
  assign wr_ctrl   = i_request & i_rw & (i_address == ADDR_CTRL);
  assign wr_target = i_request & i_rw & (i_address == ADDR_TARGET);
  assign wr_fade   = i_request & i_rw & (i_address == ADDR_FADE);

  // The top write byte carries no register field.
  assign unused_wdata = ^i_wdata[31:24];

  // A fade step happens when the step counter reaches FADE-1.
  assign step_wrap   = (fade_reg != 16'd0) && (step_reg == (fade_reg - 16'd1));
  // PWM tick and end-of-period markers; nothing advances while disabled.
  assign presc_wrap  = enable_reg && (presc_reg == PRESC_LAST);
  assign period_wrap = presc_wrap && (period_reg == 8'hFF);

  assign busy = (current_bus != target_bus);

  // CTRL register: enable and invert bits.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      enable_reg <= 1'b0;
      invert_reg <= 1'b0;
    end else if (wr_ctrl) begin
      enable_reg <= i_wdata[0];
      invert_reg <= i_wdata[1];
    end
  end

  // FADE register: clocks per fade step, 0 means follow TARGET immediately.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      fade_reg <= 16'd0;
    end else if (wr_fade) begin
      fade_reg <= i_wdata[15:0];
    end
  end

  // Fade step counter: restarts on a FADE write, idles at 0 when FADE is 0.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      step_reg <= 16'd0;
    end else if (wr_fade || (fade_reg == 16'd0) || step_wrap) begin
      step_reg <= 16'd0;
    end else begin
      step_reg <= step_reg + 16'd1;
    end
  end

  // Prescaler and 8-bit period counter, both parked at 0 while disabled.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      presc_reg  <= '0;
      period_reg <= 8'd0;
    end else if (!enable_reg) begin
      presc_reg  <= '0;
      period_reg <= 8'd0;
    end else if (presc_wrap) begin
      presc_reg  <= '0;
      period_reg <= period_reg + 8'd1;
    end else begin
      presc_reg  <= presc_reg + PRESC_W'(1);
    end
  end

  // Per-channel TARGET, CURRENT, period-latched compare and output flop.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] target_reg;
      logic [7:0] current_reg;
      logic [7:0] compare_reg;
      logic       led_reg;

      // TARGET byte for this channel.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          target_reg <= 8'd0;
        end else if (wr_target) begin
          target_reg <= i_wdata[8*gi +: 8];
        end
      end

      // CURRENT: jump to TARGET when not fading, else one step per wrap.
      // A TARGET write landing on a wrap edge is seen only afterwards, so
      // the step in that cycle still heads toward the old target.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          current_reg <= 8'd0;
        end else if (fade_reg == 16'd0) begin
          current_reg <= target_reg;
        end else if (step_wrap) begin
          if (current_reg < target_reg) begin
            current_reg <= current_reg + 8'd1;
          end else if (current_reg > target_reg) begin
            current_reg <= current_reg - 8'd1;
          end
        end
      end

      // Compare latch: refreshed only at the period wrap or while disabled,
      // so a running period always completes with the duty it started with.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          compare_reg <= 8'd0;
        end else if (!enable_reg || period_wrap) begin
          compare_reg <= current_reg;
        end
      end

      // Registered PWM output with optional inversion.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          led_reg <= 1'b0;
        end else begin
          led_reg <= invert_reg ^ (enable_reg & (period_reg < compare_reg));
        end
      end

      assign target_bus[8*gi +: 8]  = target_reg;
      assign current_bus[8*gi +: 8] = current_reg;
      assign o_led[gi]              = led_reg;
    end
  endgenerate

  // Read multiplexer; unused bits and unmapped indexes return 0.
  always_comb begin
    read_data = 32'd0;
    case (i_address)
      ADDR_CTRL:    read_data = {30'd0, invert_reg, enable_reg};
      ADDR_TARGET:  read_data = {8'd0, target_bus};
      ADDR_FADE:    read_data = {16'd0, fade_reg};
      ADDR_CURRENT: read_data = {8'd0, current_bus};
      ADDR_STATUS:  read_data = {31'd0, busy};
      default:      read_data = 32'd0;
    endcase
  end

  // Bus acknowledge follows the request by one cycle; read data is captured
  // alongside it and otherwise held.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ready_reg <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      ready_reg <= i_request;
      if (i_request) begin
        rdata_reg <= read_data;
      end
    end
  end

  assign o_ready = ready_reg;
  assign o_rdata = rdata_reg;

endmodule
